// File: rtl/conv_tree_serializer.sv
// conv_tree_serializer: parallel-to-serial converter.
// Captures an INPUTS_NUM-bit word once per INPUTS_NUM-clock frame. The word
// is then shifted out one bit per clock on SERIAL_OUT, with no gap between
// frames. A binary 2:1 mux tree selects the bit, steered by a free-running
// frame counter. The output is registered.
// Optional macro MSB_FIRST_EN: when defined, the MSB is transmitted first.
// When it is undefined, the LSB is transmitted first.
module conv_tree_serializer #(
  parameter int INPUTS_NUM = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INPUTS_NUM-1:0] PAR_IN,
  output logic                  SERIAL_OUT
);

  localparam int SEL_W = (INPUTS_NUM > 1) ? $clog2(INPUTS_NUM) : 1;
  localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(INPUTS_NUM - 1);

  // The mux tree and the wrapping counter only line up for powers of two.
  generate
    if ((INPUTS_NUM < 2) || ((INPUTS_NUM & (INPUTS_NUM - 1)) != 0)) begin : g_bad_param
      $error("conv_tree_serializer: INPUTS_NUM must be a power of two and >= 2");
    end
  endgenerate

  logic [SEL_W-1:0]      cnt;
  logic [SEL_W-1:0]      sel;
  logic [INPUTS_NUM-1:0] hold;
  logic                  tree_out;

  // For a power-of-two width, inverting the counter gives INPUTS_NUM-1-cnt.
  // That reverses the bit order without changing frame timing.
`ifdef MSB_FIRST_EN
  assign sel = ~cnt;
`else
  assign sel = cnt;
`endif

  // The mux tree is built as levels, where depth 0 is the root and depth
  // SEL_W holds the leaves (the hold bits).
  // A node at depth d selects between its two children using sel[SEL_W-1-d].
  // As a result, the leaf-side level is steered by sel[0] and the root by sel[SEL_W-1].
  generate
    for (genvar d = 0; d <= SEL_W; d++) begin : g_lvl
      logic [(1 << d)-1:0] node;
      if (d == SEL_W) begin : g_leaf
        assign node = hold;
      end else begin : g_mux
        for (genvar k = 0; k < (1 << d); k++) begin : g_node
          assign node[k] = sel[SEL_W-1-d] ? g_lvl[d+1].node[2*k+1]
                                          : g_lvl[d+1].node[2*k];
        end
      end
    end
  endgenerate

  assign tree_out = g_lvl[0].node[0];

  // Frame counter, capture register and output flop; reset wins over all updates.
  // NOTE: state uses non-blocking assignments. Then SERIAL_OUT registers the
  // bit chosen by the *current* cnt and hold. Capture and count advance
  // together on the same edge, without one update racing the other.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= '0;
      hold       <= '0;
      SERIAL_OUT <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      SERIAL_OUT <= tree_out;
      if (cnt == CNT_LAST) begin
        hold <= PAR_IN;
      end
    end
  end

endmodule

// File: tb/tb_conv_tree_serializer.sv
// Testbench for conv_tree_serializer.
// A 16-bit instance is driven from a table of per-clock records, each holding
// reset, parallel word and expected output bit. Instances of width 8, 4 and 2
// share the clock and reset. They hold constant words, and their expected
// bits come from a small frame model.
// Honours MSB_FIRST_EN when computing the expected bit order.
module tb_conv_tree_serializer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] par16;
  logic [7:0]  par8;
  logic [3:0]  par4;
  logic [1:0]  par2;
  logic        so16, so8, so4, so2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  conv_tree_serializer #(.INPUTS_NUM(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .PAR_IN(par16), .SERIAL_OUT(so16));
  conv_tree_serializer #(.INPUTS_NUM(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .PAR_IN(par8), .SERIAL_OUT(so8));
  conv_tree_serializer #(.INPUTS_NUM(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .PAR_IN(par4), .SERIAL_OUT(so4));
  conv_tree_serializer #(.INPUTS_NUM(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .PAR_IN(par2), .SERIAL_OUT(so2));

  typedef struct {
    logic        rst;
    logic [15:0] par;
    logic        exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit i (0 = first transmitted) of a 16-bit frame.
  function automatic logic frame_bit(input logic [15:0] word, input int i);
`ifdef MSB_FIRST_EN
    return word[15-i];
`else
    return word[i];
`endif
  endfunction

  // Expected output of an n-wide instance, k non-reset edges after release,
  // with the word held constant: zeros until the first capture at edge n.
  // After that, bit (k-1) mod n of the word is transmitted.
  function automatic logic sweep_bit(input logic [15:0] word, input int n, input int k);
    int idx;
    if (k <= n) return 1'b0;
    idx = (k - 1) % n;
`ifdef MSB_FIRST_EN
    idx = n - 1 - idx;
`endif
    return word[idx];
  endfunction

  task automatic push(input logic rst, input logic [15:0] par, input logic exp);
    vec_t v;
    v.rst = rst;
    v.par = par;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Watchdog: the run is a fixed number of clocks, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;

    RESET = 1'b1;
    par16 = 16'hFFFF;
    par8  = 8'b1010_1111;
    par4  = 4'b1011;
    par2  = 2'b10;

    // Three reset clocks with all-ones input: output stays 0.
    for (int i = 0; i < 3; i++) push(1'b1, 16'hFFFF, 1'b0);
    // Edges 1..16 after release: hold is still 0; capture of C5AF on edge 16.
    for (int i = 0; i < 16; i++) push(1'b0, 16'hC5AF, 1'b0);
    // C5AF frame out; PAR_IN drops to 0 in time for the next capture.
    for (int i = 0; i < 16; i++) push(1'b0, 16'h0000, frame_bit(16'hC5AF, i));
    // Gapless all-zero frame; 3C96 presented for the capture that follows.
    for (int i = 0; i < 16; i++) push(1'b0, 16'h3C96, 1'b0);
    // 3C96 frame; PAR_IN changes to FFFF at cnt=5 without disturbing it.
    for (int i = 0; i < 16; i++) push(1'b0, (i < 5) ? 16'h3C96 : 16'hFFFF, frame_bit(16'h3C96, i));
    // FFFF frame aborted by a one-clock reset at cnt=7.
    for (int i = 0; i < 7; i++) push(1'b0, 16'hFFFF, 1'b1);
    push(1'b1, 16'hFFFF, 1'b0);
    // Framing restarts: 16 zero edges, capture of A5F0 on the 16th.
    for (int i = 0; i < 16; i++) push(1'b0, 16'hA5F0, 1'b0);
    for (int i = 0; i < 16; i++) push(1'b0, 16'h0000, frame_bit(16'hA5F0, i));

    k = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      RESET = vecs[i].rst;
      par16 = vecs[i].par;
      tick();
      check($sformatf("n16_out row %0d", i), 32'(so16), 32'(vecs[i].exp));
      if (vecs[i].rst) begin
        check($sformatf("n16_cnt_reset row %0d", i), 32'(dut16.cnt), 32'd0);
        k = 0;
      end else begin
        k++;
      end
      // Width sweep over the first 40 edges after the initial release.
      if (i < 43) begin
        check($sformatf("n8_out k=%0d", k), 32'(so8), 32'(sweep_bit(16'(par8), 8, k)));
        check($sformatf("n4_out k=%0d", k), 32'(so4), 32'(sweep_bit(16'(par4), 4, k)));
        check($sformatf("n2_out k=%0d", k), 32'(so2), 32'(sweep_bit(16'(par2), 2, k)));
      end
    end

    // Hand sequence: one-clock reset, then the 2-wide and 4-wide instances
    // restart framing with new words.
    RESET = 1'b1;
    par2  = 2'b01;
    par4  = 4'b0110;
    tick();
    check("n2_out reset", 32'(so2), 32'd0);
    check("n4_out reset", 32'(so4), 32'd0);
    check("n2_cnt reset", 32'(dut2.cnt), 32'd0);
    RESET = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check($sformatf("n2_restart k=%0d", j), 32'(so2), 32'(sweep_bit(16'(par2), 2, j)));
      check($sformatf("n4_restart k=%0d", j), 32'(so4), 32'(sweep_bit(16'(par4), 4, j)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
